// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding into the ALU operands.
// Latency: 1 cycle from decode accept to ex_valid; operands are combinational from held state and bypass inputs.
// Backpressure: id_ready drops while a held instruction stalls (ex_ready low) or on flush; held operands keep tracking bypass data.

`ifndef ALU_si
`define ALU_si logic [3:0]
`endif

module id_ex_stage #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,

  // Decode side
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_imm,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic [4:0]  id_rd_addr,
  input  logic        id_use_pc,
  input  logic        id_use_imm,
  input  logic        id_reg_write,
  input  `ALU_si      id_alu_op,

  // Redirect
  input  logic        flush,

  // Bypass sources
  input  logic        mem_reg_write,
  input  logic        wb_reg_write,
  input  logic [4:0]  mem_rd_addr,
  input  logic [4:0]  wb_rd_addr,
  input  logic [31:0] mem_result,
  input  logic [31:0] wb_result,

  // Execute side
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic        alu_enable,
  output logic [31:0] src1,
  output logic [31:0] src2,
  output `ALU_si      alu_op,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_rd_addr,
  output logic        ex_reg_write
);

  // Held instruction state
  logic        ex_valid_q,   ex_valid_d;
  logic [31:0] pc_q,         pc_d;
  logic [31:0] imm_q,        imm_d;
  logic [31:0] rs1_data_q,   rs1_data_d;
  logic [31:0] rs2_data_q,   rs2_data_d;
  logic [4:0]  rs1_addr_q,   rs1_addr_d;
  logic [4:0]  rs2_addr_q,   rs2_addr_d;
  logic [4:0]  rd_addr_q,    rd_addr_d;
  logic        use_pc_q,     use_pc_d;
  logic        use_imm_q,    use_imm_d;
  logic        reg_write_q,  reg_write_d;
  `ALU_si      alu_op_q,     alu_op_d;

  logic        accept;
  logic        stall;
  logic [31:0] rs1_fwd;
  logic [31:0] rs2_fwd;

  // Handshake: a new instruction may enter when the slot is empty or draining, never during a redirect.
  assign id_ready = (!ex_valid_q || ex_ready) && !flush;
  assign accept   = id_valid && id_ready;
  assign stall    = ex_valid_q && !ex_ready;

  // Operand bypass for rs1: MEM is younger than WB so it wins; x0 is hard-wired and never bypassed.
  always_comb begin
    rs1_fwd = rs1_data_q;
    if (FWD_EN && mem_reg_write && (mem_rd_addr == rs1_addr_q) && (rs1_addr_q != 5'd0)) begin
      rs1_fwd = mem_result;
    end else if (FWD_EN && wb_reg_write && (wb_rd_addr == rs1_addr_q) && (rs1_addr_q != 5'd0)) begin
      rs1_fwd = wb_result;
    end
  end

  // Operand bypass for rs2, same priority rules as rs1.
  always_comb begin
    rs2_fwd = rs2_data_q;
    if (FWD_EN && mem_reg_write && (mem_rd_addr == rs2_addr_q) && (rs2_addr_q != 5'd0)) begin
      rs2_fwd = mem_result;
    end else if (FWD_EN && wb_reg_write && (wb_rd_addr == rs2_addr_q) && (rs2_addr_q != 5'd0)) begin
      rs2_fwd = wb_result;
    end
  end

  // Next-state: flush kills, accept loads, stall holds while folding in bypass data, drain empties.
  always_comb begin
    ex_valid_d  = ex_valid_q;
    pc_d        = pc_q;
    imm_d       = imm_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rd_addr_d   = rd_addr_q;
    use_pc_d    = use_pc_q;
    use_imm_d   = use_imm_q;
    reg_write_d = reg_write_q;
    alu_op_d    = alu_op_q;

    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      ex_valid_d  = 1'b1;
      pc_d        = id_pc;
      imm_d       = id_imm;
      rs1_data_d  = id_rs1_data;
      rs2_data_d  = id_rs2_data;
      rs1_addr_d  = id_rs1_addr;
      rs2_addr_d  = id_rs2_addr;
      rd_addr_d   = id_rd_addr;
      use_pc_d    = id_use_pc;
      use_imm_d   = id_use_imm;
      reg_write_d = id_reg_write;
      alu_op_d    = id_alu_op;
    end else if (stall) begin
      // A producer may retire from WB while we wait; capture its value now or it is gone.
      rs1_data_d = rs1_fwd;
      rs2_data_d = rs2_fwd;
    end else if (ex_valid_q) begin
      ex_valid_d = 1'b0;
    end
  end

  // State register with asynchronous clear; an instruction held at reset is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      pc_q        <= '0;
      imm_q       <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_addr_q   <= '0;
      use_pc_q    <= 1'b0;
      use_imm_q   <= 1'b0;
      reg_write_q <= 1'b0;
      alu_op_q    <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      pc_q        <= pc_d;
      imm_q       <= imm_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rd_addr_q   <= rd_addr_d;
      use_pc_q    <= use_pc_d;
      use_imm_q   <= use_imm_d;
      reg_write_q <= reg_write_d;
      alu_op_q    <= alu_op_d;
    end
  end

  // Execute outputs are forced to zero when the slot is empty so the ALU sees quiet inputs.
  always_comb begin
    src1          = '0;
    src2          = '0;
    ex_store_data = '0;
    alu_op        = '0;
    if (ex_valid_q) begin
      src1          = use_pc_q  ? pc_q  : rs1_fwd;
      src2          = use_imm_q ? imm_q : rs2_fwd;
      ex_store_data = rs2_fwd;
      alu_op        = alu_op_q;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign alu_enable   = ex_valid_q;
  assign ex_rd_addr   = rd_addr_q;
  assign ex_reg_write = reg_write_q && ex_valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
`ifndef ALU_si
`define ALU_si logic [3:0]
`endif

module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc, id_imm, id_rs1_data, id_rs2_data;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        id_use_pc, id_use_imm, id_reg_write;
  logic [3:0]  id_alu_op;
  logic        flush;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic [31:0] mem_result, wb_result;
  logic        ex_ready;
  logic        ex_valid, alu_enable;
  logic [31:0] src1, src2, ex_store_data;
  logic [3:0]  alu_op;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write;

  always #5 clk = ~clk;

  id_ex_stage #(.FWD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_imm(id_imm), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_use_pc(id_use_pc), .id_use_imm(id_use_imm), .id_reg_write(id_reg_write),
    .id_alu_op(id_alu_op), .flush(flush),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .mem_rd_addr(mem_rd_addr), .wb_rd_addr(wb_rd_addr),
    .mem_result(mem_result), .wb_result(wb_result),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .alu_enable(alu_enable),
    .src1(src1), .src2(src2), .alu_op(alu_op), .ex_store_data(ex_store_data),
    .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write)
  );

  typedef struct {
    logic [4:0]  rs1a, rs2a, rd;
    logic [31:0] rs1d, rs2d, pc, imm;
    logic        use_pc, use_imm, regw;
    logic [3:0]  op;
    logic        mem_w;  logic [4:0] mem_rd; logic [31:0] mem_res;
    logic        wb_w;   logic [4:0] wb_rd;  logic [31:0] wb_res;
    logic [31:0] e_src1, e_src2, e_store;
  } vec_t;

  typedef struct {
    logic [31:0] src1, src2, store;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        regw;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic clear_fwd();
    mem_reg_write = 1'b0; mem_rd_addr = '0; mem_result = '0;
    wb_reg_write  = 1'b0; wb_rd_addr  = '0; wb_result  = '0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] r1d,
                       input logic [31:0] r2d, input logic [4:0] r1a, input logic [4:0] r2a,
                       input logic [4:0] rd, input logic upc, input logic uimm,
                       input logic regw, input logic [3:0] op);
    id_valid = 1'b1; id_pc = pc; id_imm = imm; id_rs1_data = r1d; id_rs2_data = r2d;
    id_rs1_addr = r1a; id_rs2_addr = r2a; id_rd_addr = rd;
    id_use_pc = upc; id_use_imm = uimm; id_reg_write = regw; id_alu_op = op;
  endtask

  task automatic push_exp(input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] st,
                          input logic [3:0] op, input logic [4:0] rd, input logic regw);
    exp_t e;
    e.src1 = s1; e.src2 = s2; e.store = st; e.op = op; e.rd = rd; e.regw = regw;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard_empty actual=output required=expected_entry", tag);
    end else begin
      checks--;
      e = sb.pop_front();
      chk({tag, ".src1"}, src1, e.src1);
      chk({tag, ".src2"}, src2, e.src2);
      chk({tag, ".store"}, ex_store_data, e.store);
      chk({tag, ".alu_op"}, {28'd0, alu_op}, {28'd0, e.op});
      chk({tag, ".rd"}, {27'd0, ex_rd_addr}, {27'd0, e.rd});
      chk({tag, ".regw"}, {31'd0, ex_reg_write}, {31'd0, e.regw});
      chk({tag, ".alu_en"}, {31'd0, alu_enable}, 32'd1);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ex_valid"}, {31'd0, ex_valid}, 32'd0);
    chk({tag, ".alu_en"}, {31'd0, alu_enable}, 32'd0);
    chk({tag, ".src1"}, src1, 32'd0);
    chk({tag, ".src2"}, src2, 32'd0);
    chk({tag, ".store"}, ex_store_data, 32'd0);
    chk({tag, ".alu_op"}, {28'd0, alu_op}, 32'd0);
    chk({tag, ".regw"}, {31'd0, ex_reg_write}, 32'd0);
  endtask

  // Watchdog: the sequence is fixed-length, so reaching this means something hung.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    //          rs1a  rs2a  rd    rs1d         rs2d         pc            imm          upc   uimm  regw  op     mem_w mem_rd mem_res       wb_w  wb_rd  wb_res        e_src1        e_src2        e_store
    vecs[0] = '{5'd1, 5'd2, 5'd5, 32'h5,       32'h7,       32'h100,      32'h8,       1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        32'h5,        32'h7,        32'h7};
    vecs[1] = '{5'd3, 5'd4, 5'd6, 32'hAA,      32'h99,      32'h104,      32'h0,       1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 5'd3,  32'h11,       1'b1, 5'd3,  32'h22,       32'h11,       32'h99,       32'h99};
    vecs[2] = '{5'd0, 5'd4, 5'd6, 32'h0,       32'h99,      32'h108,      32'h0,       1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 5'd0,  32'h11,       1'b1, 5'd0,  32'h22,       32'h0,        32'h99,       32'h99};
    vecs[3] = '{5'd1, 5'd6, 5'd7, 32'h31,      32'h62,      32'h10C,      32'h0,       1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 5'd7,  32'h77,       1'b1, 5'd6,  32'h1234,     32'h31,       32'h1234,     32'h1234};
    vecs[4] = '{5'd9, 5'd2, 5'd8, 32'h5,       32'h6,       32'h1000,     32'h40,      1'b1, 1'b1, 1'b0, 4'd3, 1'b1, 5'd2,  32'h55,       1'b0, 5'd0,  32'h0,        32'h1000,     32'h40,       32'h55};
    vecs[5] = '{5'd8, 5'd9, 5'd1, 32'h321,     32'h654,     32'h110,      32'h0,       1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 5'd8,  32'hDEAD,     1'b0, 5'd9,  32'hBEEF,     32'h321,      32'h654,      32'h654};
    vecs[6] = '{5'd2, 5'd12, 5'd3, 32'h1,      32'h2,       32'h114,      32'h0,       1'b0, 1'b0, 1'b1, 4'd6, 1'b1, 5'd12, 32'hA5,       1'b1, 5'd12, 32'h5A,       32'h1,        32'hA5,       32'hA5};

    // Reset state
    rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b0;
    drive('0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 4'd0);
    id_valid = 1'b0;
    clear_fwd();
    #12;
    chk_all_zero("reset");
    chk("reset.rd", {27'd0, ex_rd_addr}, 32'd0);
    chk("reset.id_ready", {31'd0, id_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    ex_ready = 1'b1;
    #1;
    chk("post_reset.id_ready", {31'd0, id_ready}, 32'd1);

    // Table of single instructions with bypass data applied in the execute cycle
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      clear_fwd();
      drive(vecs[i].pc, vecs[i].imm, vecs[i].rs1d, vecs[i].rs2d, vecs[i].rs1a, vecs[i].rs2a,
            vecs[i].rd, vecs[i].use_pc, vecs[i].use_imm, vecs[i].regw, vecs[i].op);
      push_exp(vecs[i].e_src1, vecs[i].e_src2, vecs[i].e_store, vecs[i].op, vecs[i].rd, vecs[i].regw);
      @(negedge clk);
      id_valid = 1'b0;
      mem_reg_write = vecs[i].mem_w; mem_rd_addr = vecs[i].mem_rd; mem_result = vecs[i].mem_res;
      wb_reg_write  = vecs[i].wb_w;  wb_rd_addr  = vecs[i].wb_rd;  wb_result  = vecs[i].wb_res;
      #1;
      chk($sformatf("vec%0d.ex_valid", i), {31'd0, ex_valid}, 32'd1);
      pop_check($sformatf("vec%0d", i));
    end
    @(negedge clk);
    clear_fwd();
    #1;
    chk("drain.ex_valid", {31'd0, ex_valid}, 32'd0);

    // Stall three cycles; WB produces rs2 only in the first stall cycle
    @(negedge clk);
    drive(32'h200, 32'h0, 32'h3, 32'h7, 5'd1, 5'd5, 5'd9, 1'b0, 1'b0, 1'b1, 4'd2);
    @(negedge clk);
    ex_ready = 1'b0;
    drive(32'h300, 32'h0, 32'hBAD, 32'hBAD, 5'd1, 5'd5, 5'd10, 1'b0, 1'b0, 1'b1, 4'd7);
    wb_reg_write = 1'b1; wb_rd_addr = 5'd5; wb_result = 32'h44;
    #1;
    chk("stall1.id_ready", {31'd0, id_ready}, 32'd0);
    chk("stall1.src2", src2, 32'h44);
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      clear_fwd();
      #1;
      chk($sformatf("stall%0d.id_ready", c), {31'd0, id_ready}, 32'd0);
      chk($sformatf("stall%0d.ex_valid", c), {31'd0, ex_valid}, 32'd1);
      chk($sformatf("stall%0d.src2", c), src2, 32'h44);
    end
    @(negedge clk);
    id_valid = 1'b0;
    ex_ready = 1'b1;
    #1;
    chk("release.src2", src2, 32'h44);
    chk("release.store", ex_store_data, 32'h44);
    chk("release.src1", src1, 32'h3);
    chk("release.rd", {27'd0, ex_rd_addr}, 32'd9);
    chk("release.id_ready", {31'd0, id_ready}, 32'd1);
    @(negedge clk);
    #1;
    chk("release_drain.ex_valid", {31'd0, ex_valid}, 32'd0);

    // Flush against an incoming instruction
    @(negedge clk);
    drive(32'h400, 32'h4, 32'h9, 32'h8, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 4'd1);
    flush = 1'b1;
    #1;
    chk("flush_in.id_ready", {31'd0, id_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    id_valid = 1'b0;
    #1;
    chk_all_zero("flush_in");

    // Flush of a stalled instruction
    @(negedge clk);
    drive(32'h500, 32'h4, 32'h9, 32'h8, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 4'd1);
    @(negedge clk);
    id_valid = 1'b0;
    ex_ready = 1'b0;
    #1;
    chk("flush_held.pre_valid", {31'd0, ex_valid}, 32'd1);
    @(negedge clk);
    flush = 1'b1;
    drive(32'h600, 32'h4, 32'h9, 32'h8, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 4'd1);
    @(negedge clk);
    flush = 1'b0;
    id_valid = 1'b0;
    ex_ready = 1'b1;
    #1;
    chk_all_zero("flush_held");

    // Back-to-back accepts, one per cycle, immediate as src2
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      #1;
      if (i > 0) begin
        chk($sformatf("b2b%0d.ex_valid", i), {31'd0, ex_valid}, 32'd1);
        pop_check($sformatf("b2b%0d", i));
      end
      if (i < 4) begin
        chk($sformatf("b2b%0d.id_ready", i), {31'd0, id_ready}, 32'd1);
        drive(32'h700 + 32'(i * 4), 32'hFFFF_FFF0, 32'h20 + 32'(i), 32'h101 + 32'(i * 256),
              5'd1, 5'(10 + i), 5'(20 + i), 1'b0, 1'b1, 1'b1, 4'(8 + i));
        push_exp(32'h20 + 32'(i), 32'hFFFF_FFF0, 32'h101 + 32'(i * 256), 4'(8 + i), 5'(20 + i), 1'b1);
      end else begin
        id_valid = 1'b0;
      end
    end
    chk("b2b.sb_empty", 32'(sb.size()), 32'd0);

    // Asynchronous reset in the middle of a stall
    @(negedge clk);
    drive(32'h800, 32'h0, 32'h66, 32'h77, 5'd4, 5'd5, 5'd6, 1'b0, 1'b0, 1'b1, 4'd3);
    @(negedge clk);
    id_valid = 1'b0;
    ex_ready = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    chk("async_rst.rd", {27'd0, ex_rd_addr}, 32'd0);
    chk("async_rst.id_ready", {31'd0, id_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    ex_ready = 1'b1;
    drive(32'h900, 32'h0, 32'h13, 32'h14, 5'd1, 5'd2, 5'd11, 1'b0, 1'b0, 1'b1, 4'd9);
    push_exp(32'h13, 32'h14, 32'h14, 4'd9, 5'd11, 1'b1);
    @(negedge clk);
    id_valid = 1'b0;
    #1;
    chk("after_rst.ex_valid", {31'd0, ex_valid}, 32'd1);
    pop_check("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
